// File: rtl/usb4_ser_pkg.sv
// Shared definitions for the two-lane transmit serializer: symbol lengths,
// gen_speed encoding and FSM state type.
package usb4_ser_pkg;

    localparam int SYM_LEN_G2 = 66;
    localparam int SYM_LEN_G3 = 132;
    localparam int SYM_LEN_G4 = 8;

    typedef enum logic [1:0] {
        GEN4 = 2'd0,
        GEN3 = 2'd1,
        GEN2 = 2'd2
    } gen_speed_e;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_e;

    // Counter reload value (N-1); reserved speed code 3 yields 0 and is never loaded.
    function automatic logic [7:0] sym_len_m1(input logic [1:0] speed);
        case (speed)
            GEN4:    return 8'(SYM_LEN_G4 - 1);
            GEN3:    return 8'(SYM_LEN_G3 - 1);
            GEN2:    return 8'(SYM_LEN_G2 - 1);
            default: return 8'd0;
        endcase
    endfunction

endpackage

// File: rtl/lanes_serializer_lane_shifter.sv
// One lane's datapath: holding register, shift register and the transmit-order
// reorder applied when a symbol enters either register.
module lane_shifter
    import usb4_ser_pkg::*;
#(
    parameter int SYM_W = 132
) (
    input  logic             ser_clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             cap,
    input  logic             load_in,
    input  logic             load_hold,
    input  logic             shift_en,
    input  logic [1:0]       gen_speed,
    input  logic [SYM_W-1:0] enc,
    output logic             tx_bit
);

    logic [SYM_W-1:0] ord_g3;
    logic [SYM_W-1:0] enc_ord;
    logic [SYM_W-1:0] hold_reg;
    logic [SYM_W-1:0] shift_reg;
    logic             tx_bit_reg;

    // 132-bit symbols carry their 4-bit header in the top bits but send it first.
    genvar gi;
    generate
        for (gi = 0; gi < SYM_W; gi++) begin : g_ord
            if (gi < 4) begin : g_hdr
                assign ord_g3[gi] = enc[128 + gi];
            end else if (gi < 132) begin : g_pay
                assign ord_g3[gi] = enc[gi - 4];
            end else begin : g_pad
                assign ord_g3[gi] = 1'b0;
            end
        end
    endgenerate

    // Stored symbols are kept in transmit order: bit 0 goes out first.
    always_comb begin
        enc_ord = '0;
        case (gen_speed)
            GEN4:    enc_ord = {{(SYM_W-8){1'b0}}, enc[7:0]};
            GEN3:    enc_ord = ord_g3;
            GEN2:    enc_ord = {{(SYM_W-66){1'b0}}, enc[65:0]};
            default: enc_ord = '0;
        endcase
    end

    always_ff @(posedge ser_clk or negedge rst) begin
        if (!rst) begin
            hold_reg   <= '0;
            shift_reg  <= '0;
            tx_bit_reg <= 1'b0;
        end else if (clr) begin
            hold_reg   <= '0;
            shift_reg  <= '0;
            tx_bit_reg <= 1'b0;
        end else begin
            if (cap) begin
                hold_reg <= enc_ord;
            end
            if (load_in) begin
                tx_bit_reg <= enc_ord[0];
                shift_reg  <= enc_ord >> 1;
            end else if (load_hold) begin
                tx_bit_reg <= hold_reg[0];
                shift_reg  <= hold_reg >> 1;
            end else if (shift_en) begin
                tx_bit_reg <= shift_reg[0];
                shift_reg  <= shift_reg >> 1;
            end else begin
                tx_bit_reg <= 1'b0;
            end
        end
    end

    assign tx_bit = tx_bit_reg;

endmodule

// File: rtl/lanes_serializer.sv
// Two-lane symbol serializer: shared FSM, bit counter, holding-register
// bookkeeping and overflow flag; per-lane datapath lives in lane_shifter.
module lanes_serializer
    import usb4_ser_pkg::*;
#(
    parameter int SYM_W = 132,
    parameter int CNT_W = 8
) (
    input  logic             ser_clk,
    input  logic             rst,
    input  logic             enable_ser,
    input  logic [1:0]       gen_speed,
    input  logic [SYM_W-1:0] lane_0_tx_enc,
    input  logic [SYM_W-1:0] lane_1_tx_enc,
    input  logic             sym_valid,
    output logic             sym_ready,
    output logic             lane_0_tx_bit,
    output logic             lane_1_tx_bit,
    output logic             tx_active,
    output logic             sym_start,
    output logic             ovf_err
);

    ser_state_e       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [CNT_W-1:0] hold_len_reg, hold_len_next;
    logic             hold_valid_reg, hold_valid_next;
    logic             ovf_reg, ovf_next;
    logic             active_reg, active_next;
    logic             start_reg, start_next;

    logic             clr, cap, load_in, load_hold, shift_en;
    logic             accept_ok;
    logic             last_bit;
    logic [CNT_W-1:0] len_in;

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        hold_len_next   = hold_len_reg;
        hold_valid_next = hold_valid_reg;
        ovf_next        = ovf_reg;
        active_next     = 1'b0;
        start_next      = 1'b0;
        clr             = 1'b0;
        cap             = 1'b0;
        load_in         = 1'b0;
        load_hold       = 1'b0;
        shift_en        = 1'b0;
        accept_ok       = sym_valid && (gen_speed != 2'd3);
        len_in          = CNT_W'(sym_len_m1(gen_speed));
        last_bit        = (cnt_reg == '0);

        if (!enable_ser) begin
            state_next      = IDLE;
            cnt_next        = '0;
            hold_len_next   = '0;
            hold_valid_next = 1'b0;
            ovf_next        = 1'b0;
            clr             = 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept_ok) begin
                        load_in     = 1'b1;
                        cnt_next    = len_in;
                        state_next  = SHIFT;
                        active_next = 1'b1;
                        start_next  = 1'b1;
                    end
                end
                SHIFT: begin
                    active_next = 1'b1;
                    if (!last_bit) begin
                        shift_en = 1'b1;
                        cnt_next = cnt_reg - CNT_W'(1);
                        if (accept_ok) begin
                            if (!hold_valid_reg) begin
                                cap             = 1'b1;
                                hold_valid_next = 1'b1;
                                hold_len_next   = len_in;
                            end else begin
                                ovf_next = 1'b1;
                            end
                        end
                    end else if (hold_valid_reg) begin
                        // Transfer edge: a symbol arriving now refills the holding register.
                        load_hold  = 1'b1;
                        cnt_next   = hold_len_reg;
                        start_next = 1'b1;
                        if (accept_ok) begin
                            cap           = 1'b1;
                            hold_len_next = len_in;
                        end else begin
                            hold_valid_next = 1'b0;
                        end
                    end else if (accept_ok) begin
                        // Nothing held: load straight into the shifter to avoid a gap.
                        load_in    = 1'b1;
                        cnt_next   = len_in;
                        start_next = 1'b1;
                    end else begin
                        state_next  = IDLE;
                        active_next = 1'b0;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge ser_clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            hold_len_reg   <= '0;
            hold_valid_reg <= 1'b0;
            ovf_reg        <= 1'b0;
            active_reg     <= 1'b0;
            start_reg      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            hold_len_reg   <= hold_len_next;
            hold_valid_reg <= hold_valid_next;
            ovf_reg        <= ovf_next;
            active_reg     <= active_next;
            start_reg      <= start_next;
        end
    end

    logic [SYM_W-1:0] lane_enc [2];
    logic [1:0]       lane_bit;

    assign lane_enc[0] = lane_0_tx_enc;
    assign lane_enc[1] = lane_1_tx_enc;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            lane_shifter #(
                .SYM_W (SYM_W)
            ) u_lane_shifter (
                .ser_clk   (ser_clk),
                .rst       (rst),
                .clr       (clr),
                .cap       (cap),
                .load_in   (load_in),
                .load_hold (load_hold),
                .shift_en  (shift_en),
                .gen_speed (gen_speed),
                .enc       (lane_enc[gi]),
                .tx_bit    (lane_bit[gi])
            );
        end
    endgenerate

    assign lane_0_tx_bit = lane_bit[0];
    assign lane_1_tx_bit = lane_bit[1];
    assign sym_ready     = ~hold_valid_reg;
    assign tx_active     = active_reg;
    assign sym_start     = start_reg;
    assign ovf_err       = ovf_reg;

endmodule

// File: tb/tb_lanes_serializer.sv
// Self-checking bench for lanes_serializer: queue-based reference model compared
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_lanes_serializer;

    localparam int SYM_W = 132;
    localparam int CNT_W = 8;

    logic             ser_clk = 1'b0;
    logic             rst = 1'b0;
    logic             enable_ser = 1'b0;
    logic [1:0]       gen_speed = 2'd0;
    logic [SYM_W-1:0] lane_0_tx_enc = '0;
    logic [SYM_W-1:0] lane_1_tx_enc = '0;
    logic             sym_valid = 1'b0;
    logic             sym_ready;
    logic             lane_0_tx_bit;
    logic             lane_1_tx_bit;
    logic             tx_active;
    logic             sym_start;
    logic             ovf_err;

    lanes_serializer #(
        .SYM_W (SYM_W),
        .CNT_W (CNT_W)
    ) dut (
        .ser_clk       (ser_clk),
        .rst           (rst),
        .enable_ser    (enable_ser),
        .gen_speed     (gen_speed),
        .lane_0_tx_enc (lane_0_tx_enc),
        .lane_1_tx_enc (lane_1_tx_enc),
        .sym_valid     (sym_valid),
        .sym_ready     (sym_ready),
        .lane_0_tx_bit (lane_0_tx_bit),
        .lane_1_tx_bit (lane_1_tx_bit),
        .tx_active     (tx_active),
        .sym_start     (sym_start),
        .ovf_err       (ovf_err)
    );

    always #5 ser_clk = ~ser_clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: a queue of bits still to be shown after the current cycle,
    // plus a single held symbol.
    typedef struct packed {
        bit b0;
        bit b1;
        bit st;
    } slot_t;

    slot_t      mq[$];
    bit         m_hold_v = 0;
    bit [1:0]   m_hold_spd = 0;
    bit [131:0] m_hold0 = 0;
    bit [131:0] m_hold1 = 0;
    bit         m_ovf = 0;
    bit         m_b0 = 0;
    bit         m_b1 = 0;
    bit         m_act = 0;
    bit         m_st = 0;

    function automatic int sym_n(input bit [1:0] s);
        case (s)
            2'd0:    return 8;
            2'd1:    return 132;
            2'd2:    return 66;
            default: return 0;
        endcase
    endfunction

    function automatic bit tx_order_bit(input bit [131:0] d, input bit [1:0] s, input int k);
        if (s == 2'd1) return (k < 4) ? d[128 + k] : d[k - 4];
        return d[k];
    endfunction

    task automatic push_sym(input bit [131:0] d0, input bit [131:0] d1, input bit [1:0] s);
        slot_t e;
        for (int k = 0; k < sym_n(s); k++) begin
            e.b0 = tx_order_bit(d0, s, k);
            e.b1 = tx_order_bit(d1, s, k);
            e.st = (k == 0);
            mq.push_back(e);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_hold_v = 0; m_hold_spd = 0; m_hold0 = 0; m_hold1 = 0;
        m_ovf = 0; m_b0 = 0; m_b1 = 0; m_act = 0; m_st = 0;
    endtask

    task automatic model_capture();
        m_hold0 = lane_0_tx_enc; m_hold1 = lane_1_tx_enc; m_hold_spd = gen_speed;
    endtask

    task automatic model_edge();
        bit ok;
        slot_t e;
        if (!enable_ser) begin
            model_clear();
            return;
        end
        ok = sym_valid && (gen_speed != 2'd3);
        if (mq.size() == 0) begin
            if (m_hold_v) begin
                push_sym(m_hold0, m_hold1, m_hold_spd);
                if (ok) model_capture();
                else m_hold_v = 0;
            end else if (ok) begin
                push_sym(lane_0_tx_enc, lane_1_tx_enc, gen_speed);
            end
        end else if (ok) begin
            if (!m_hold_v) begin
                model_capture();
                m_hold_v = 1;
            end else begin
                m_ovf = 1;
            end
        end
        if (mq.size() > 0) begin
            e = mq.pop_front();
            m_b0 = e.b0; m_b1 = e.b1; m_act = 1; m_st = e.st;
        end else begin
            m_b0 = 0; m_b1 = 0; m_act = 0; m_st = 0;
        end
    endtask

    always @(posedge ser_clk or negedge rst) begin
        if (!rst) model_clear();
        else model_edge();
    end

    always @(negedge ser_clk) begin
        checks++;
        if ({lane_0_tx_bit, lane_1_tx_bit, tx_active, sym_start, sym_ready, ovf_err} !==
            {m_b0, m_b1, m_act, m_st, !m_hold_v, m_ovf}) begin
            failures++;
            $display("FAIL model_cmp t=%0t got b0=%b b1=%b act=%b st=%b rdy=%b ovf=%b expected b0=%b b1=%b act=%b st=%b rdy=%b ovf=%b",
                     $time, lane_0_tx_bit, lane_1_tx_bit, tx_active, sym_start, sym_ready, ovf_err,
                     m_b0, m_b1, m_act, m_st, !m_hold_v, m_ovf);
        end
    end

    // Output recorder used by the directed scenarios.
    bit rec_on = 0;
    bit rec_b0[$];
    bit rec_b1[$];
    bit rec_act[$];
    bit rec_st[$];

    always @(negedge ser_clk) begin
        if (rec_on) begin
            rec_b0.push_back(lane_0_tx_bit);
            rec_b1.push_back(lane_1_tx_bit);
            rec_act.push_back(tx_active);
            rec_st.push_back(sym_start);
        end
    end

    function automatic int qat(input bit q[$], input int i);
        if (i < 0 || i >= q.size()) return 0;
        return int'(q[i]);
    endfunction

    function automatic int first_act();
        foreach (rec_act[i]) if (rec_act[i]) return i;
        return -1;
    endfunction

    function automatic int count_q(input bit q[$]);
        int n = 0;
        foreach (q[i]) n += int'(q[i]);
        return n;
    endfunction

    function automatic bit [131:0] rnd132();
        bit [159:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return t[131:0];
    endfunction

    task automatic step();
        @(negedge ser_clk);
        #2;
    endtask

    task automatic send(input bit [1:0] s, input bit [131:0] d0, input bit [131:0] d1);
        gen_speed = s; lane_0_tx_enc = d0; lane_1_tx_enc = d1; sym_valid = 1'b1;
        step();
        sym_valid = 1'b0;
    endtask

    task automatic rec_start();
        rec_b0.delete(); rec_b1.delete(); rec_act.delete(); rec_st.delete();
        rec_on = 1;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((tx_active || !sym_ready) && n < 400) begin
            step();
            n++;
        end
        chk({name, "_idle_timeout"}, int'(n < 400), 1);
        rec_on = 0;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!sym_ready && n < 300) begin
            step();
            n++;
        end
        chk({name, "_ready_timeout"}, int'(n < 300), 1);
    endtask

    initial begin
        int         fa;
        int         errs;
        int         w;
        bit         ex;
        bit [131:0] d;
        bit [7:0]   by [3];

        rst = 1'b0; enable_ser = 1'b1;
        repeat (3) step();
        chk("reset_ready", sym_ready, 1);
        chk("reset_active", tx_active, 0);
        chk("reset_ovf", ovf_err, 0);
        chk("reset_bits", int'(lane_0_tx_bit | lane_1_tx_bit | sym_start), 0);
        rst = 1'b1;
        step();

        // 66-bit symbol on lane 0
        d = '0;
        d[65:0] = {64'hA5A5_0000_FFFF_1234, 2'b01};
        rec_start();
        send(2'd2, d, rnd132());
        wait_idle("g2");
        fa = first_act();
        chk("g2_latency", fa, 0);
        chk("g2_active_cycles", count_q(rec_act), 66);
        chk("g2_starts", count_q(rec_st), 1);
        chk("g2_bit0", qat(rec_b0, fa), 1);
        chk("g2_bit1", qat(rec_b0, fa + 1), 0);
        errs = 0;
        for (int k = 0; k < 66; k++) if (qat(rec_b0, fa + k) != int'(d[k])) errs++;
        chk("g2_stream_errs", errs, 0);

        // 132-bit symbol on lane 1: header 0,1,0,1 then payload 1 followed by zeros
        d = {4'b1010, 128'h1};
        rec_start();
        send(2'd1, rnd132(), d);
        wait_idle("g3");
        fa = first_act();
        chk("g3_latency", fa, 0);
        chk("g3_active_cycles", count_q(rec_act), 132);
        chk("g3_starts", count_q(rec_st), 1);
        errs = 0;
        for (int k = 0; k < 132; k++) begin
            ex = (k == 1 || k == 3 || k == 4);
            if (qat(rec_b1, fa + k) != int'(ex)) errs++;
        end
        chk("g3_stream_errs", errs, 0);

        // Three back-to-back bytes
        by[0] = 8'h81; by[1] = 8'h00; by[2] = 8'hFF;
        rec_start();
        send(2'd0, 132'(by[0]), '0);
        for (int j = 1; j < 3; j++) begin
            wait_ready("bytes");
            send(2'd0, 132'(by[j]), '0);
        end
        wait_idle("bytes");
        fa = first_act();
        w = 0;
        errs = 0;
        for (int k = 0; k < 24; k++) begin
            w += qat(rec_act, fa + k);
            if (qat(rec_b0, fa + k) != int'(by[k / 8][k % 8])) errs++;
        end
        chk("bytes_contiguous", w, 24);
        chk("bytes_total_active", count_q(rec_act), 24);
        chk("bytes_starts", count_q(rec_st), 3);
        chk("bytes_stream_errs", errs, 0);

        // Overflow: third symbol arrives while one is already held
        rec_start();
        send(2'd2, rnd132(), rnd132());
        repeat (10) step();
        d = rnd132();
        send(2'd2, d, '0);
        repeat (10) step();
        send(2'd2, ~d, '0);
        chk("ovf_set", ovf_err, 1);
        chk("ovf_ready_low", sym_ready, 0);
        wait_idle("ovf");
        fa = first_act();
        chk("ovf_active_cycles", count_q(rec_act), 132);
        chk("ovf_starts", count_q(rec_st), 2);
        errs = 0;
        for (int k = 0; k < 66; k++) if (qat(rec_b0, fa + 66 + k) != int'(d[k])) errs++;
        chk("ovf_second_sym_errs", errs, 0);
        chk("ovf_sticky", ovf_err, 1);
        enable_ser = 1'b0;
        step();
        enable_ser = 1'b1;
        chk("ovf_cleared", ovf_err, 0);

        // Asynchronous reset in the middle of a 132-bit symbol with one held
        send(2'd1, rnd132(), rnd132());
        repeat (4) step();
        send(2'd0, 132'(8'hC3), '0);
        chk("rst_hold_full", sym_ready, 0);
        repeat (25) step();
        chk("rst_mid_active", tx_active, 1);
        rst = 1'b0;
        #1;
        chk("rst_async_active", tx_active, 0);
        chk("rst_async_bits", int'(lane_0_tx_bit | lane_1_tx_bit | sym_start), 0);
        chk("rst_async_ready", sym_ready, 1);
        step();
        rst = 1'b1;
        step();
        rec_start();
        send(2'd0, 132'(8'h5A), '0);
        wait_idle("rst_5a");
        fa = first_act();
        chk("rst_5a_active", count_q(rec_act), 8);
        errs = 0;
        d = 132'(8'h5A);
        for (int k = 0; k < 8; k++) if (qat(rec_b0, fa + k) != int'(d[k])) errs++;
        chk("rst_5a_stream_errs", errs, 0);

        // Reserved speed is ignored; then speed change between symbols
        send(2'd3, rnd132(), rnd132());
        repeat (3) step();
        chk("g3rsv_active", tx_active, 0);
        chk("g3rsv_ovf", ovf_err, 0);
        chk("g3rsv_ready", sym_ready, 1);
        rec_start();
        send(2'd2, rnd132(), rnd132());
        send(2'd0, rnd132(), rnd132());
        send(2'd3, rnd132(), rnd132());
        wait_idle("spdchg");
        fa = first_act();
        chk("spdchg_active", count_q(rec_act), 74);
        chk("spdchg_starts", count_q(rec_st), 2);
        chk("spdchg_second_start", qat(rec_st, fa + 66), 1);
        chk("spdchg_ovf", ovf_err, 0);

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            enable_ser    = ($urandom_range(0, 199) != 0);
            sym_valid     = ($urandom_range(0, 7) == 0);
            gen_speed     = 2'($urandom_range(0, 3));
            lane_0_tx_enc = rnd132();
            lane_1_tx_enc = rnd132();
            if ($urandom_range(0, 999) == 0) begin
                rst = 1'b0;
                #1;
                rst = 1'b1;
            end
            step();
        end
        sym_valid  = 1'b0;
        enable_ser = 1'b1;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lanes_serializer.md
# lanes_serializer

Two-lane transmit serializer directly downstream of the 64b/66b / 128b/132b encoding stage. It accepts one encoded symbol per lane (up to 132 bits) with a valid strobe and double-buffers it: one holding register plus one shift register per lane. It then shifts each symbol out one bit per clock on two serial lane outputs, with no gap between back-to-back symbols. Symbol length is selected per symbol from `gen_speed`.

## Interface
Parameters:
- `SYM_W`, 132: width of the encoded symbol input per lane.
- `CNT_W`, 8: width of the bit counter; must satisfy 2^CNT_W > SYM_W.

Ports:
- `ser_clk`  in  1  serializer clock; one bit per lane per cycle.
- `rst`  in  1  reset; asynchronous, active-low.
- `enable_ser`  in  1  block enable; low means synchronous clear of all state.
- `gen_speed`  in  2  symbol format, sampled with `sym_valid`.
  - 2: 66-bit symbol.
  - 1: 132-bit symbol.
  - 0: 8-bit byte.
  - 3: reserved.
- `lane_0_tx_enc`  in  SYM_W  lane 0 encoded symbol.
- `lane_1_tx_enc`  in  SYM_W  lane 1 encoded symbol.
- `sym_valid`  in  1  one-cycle strobe: symbol inputs are valid this cycle.
- `sym_ready`  out  1  high when the holding register is empty.
- `lane_0_tx_bit`  out  1  lane 0 serial bit.
- `lane_1_tx_bit`  out  1  lane 1 serial bit.
- `tx_active`  out  1  high on every cycle a symbol bit is on the lane outputs.
- `sym_start`  out  1  high on the cycle the first bit of a symbol is on the outputs.
- `ovf_err`  out  1  sticky; a symbol was dropped.

## Operation
- Reset values:
  - `sym_ready` = 1.
  - All other outputs 0.
  - Holding and shift registers 0; FSM in IDLE.
- `enable_ser` low has the same effect as reset, applied at the next edge. It takes priority over `sym_valid` and clears `ovf_err`.
- Symbol length N and bit order, fixed at load time:
  - gen_speed 2: N=66; bits [65:0] are sent LSB first, so the 2-bit sync header goes first.
  - gen_speed 1: N=132; bits 128,129,130,131 are sent first (header), then bits 0..127.
  - gen_speed 0: N=8; bits [7:0] are sent LSB first.
  - gen_speed 3: `sym_valid` is ignored. No load, no error.
- Both lanes always share N, counter and FSM; only the data differs.
- FSM states:
  - IDLE:
    - Outputs 0.
    - `sym_valid` loads the shift registers directly and the next state is SHIFT.
    - The holding register stays empty.
  - SHIFT:
    - Emits one bit per cycle; the counter counts down from N-1.
    - On the edge that emits the last bit (count 0):
      - If the holding register is valid, its contents load into the shift register and the state stays SHIFT.
      - Otherwise the next state is IDLE.
- Holding register:
  - In SHIFT, `sym_valid` with `sym_ready`=1 captures data and `gen_speed` and clears `sym_ready` at that edge.
  - `sym_ready` returns to 1 on the edge the holding register is transferred.
  - Simultaneous `sym_valid` and transfer on the same edge: the transfer uses the old contents, the new symbol is captured, and `sym_ready` stays 0.
- Overflow: `sym_valid` while `sym_ready`=0 drops the new symbol, keeps the held one, and sets `ovf_err` until reset or `enable_ser` low.
- `gen_speed` changes between symbols take effect per symbol; the symbol in flight is never truncated.

## Timing
- The lane outputs are registered.
- When `sym_valid` is accepted in IDLE in cycle t:
  - Bit k is on the outputs in cycle t+1+k.
  - The last bit is on the outputs in cycle t+N.
  - `sym_start` and `tx_active` go high in cycle t+1.
- Back-to-back symbols: the next symbol's bit 0 appears in cycle t+N+1. `tx_active` stays high with no gap and `sym_start` pulses again.
- Throughput: one symbol per N cycles.
- Accept-to-first-bit latency: 1 cycle from IDLE; from the holding register, it is the time until the current symbol's last bit has been emitted.
- Asynchronous reset mid-symbol: outputs go to 0 immediately and the partial symbol is discarded.

## Structure
- Shared package `usb4_ser_pkg` holds:
  - Constants `SYM_LEN_G2`=66, `SYM_LEN_G3`=132, `SYM_LEN_G4`=8.
  - A `gen_speed` enum: `GEN4`=0, `GEN3`=1, `GEN2`=2.
  - The FSM state typedef.
- Sub-module `lane_shifter` contains one lane's holding register, shift register and bit reorder for 132-bit symbols. It is instantiated twice.
- The top level owns the FSM, counter, `sym_ready` and `ovf_err`.

## Test plan
- gen_speed=2, lane 0 = {64'hA5A5_0000_FFFF_1234, 2'b01}, single `sym_valid`: the lane 0 stream starts 1,0 at cycle t+1 and ends at t+66. `tx_active` is high for exactly 66 cycles.
- gen_speed=1, lane 1 = {4'b1010, 128'h1}: the first bits are 0,1,0,1, then 1, then 127 zeros. `sym_start` pulses once.
- Three back-to-back gen_speed=0 bytes 8'h81, 8'h00, 8'hFF, each `sym_valid` issued as soon as `sym_ready` is high: 24 contiguous bits and `tx_active` has no gap.
- Two `sym_valid` pulses during one 66-bit symbol: the second is dropped and `ovf_err` becomes 1. Only two symbols are transmitted. `enable_ser` low then clears `ovf_err`.
- `rst` asserted at bit 30 of a 132-bit symbol: outputs are 0 immediately and `sym_ready`=1. After release, a new 8'h5A symbol transmits cleanly.
- gen_speed=3 with `sym_valid`: no output, no error. Then a gen_speed 2→0 change between two symbols: lengths are 66 then 8.
